// File: rtl/split_sched_pkg.sv
// split_sched_pkg: FSM state type and frame-config legality check shared by
// the split_sched controller and its bench.
package split_sched_pkg;

    localparam int unsigned DEF_BURST_LENGTH  = 32;
    localparam int unsigned DEF_KERNEL_LENGTH = 3;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} sched_state_t;

    function automatic logic cfg_ok(
        input int unsigned width,
        input int unsigned height,
        input int unsigned max_w = DEF_BURST_LENGTH,
        input int unsigned k     = DEF_KERNEL_LENGTH
    );
        return (width != 0) && (width <= max_w) && (height >= k);
    endfunction

endpackage

// File: rtl/split_sched.sv
// split_sched: meters DMA pixels into the split line-buffer cascade and tags
// each emitted column with row/col position, window status and frame end.
module split_sched
    import split_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LENGTH  = 32,
    parameter int KERNEL_LENGTH = 3,
    parameter int W_WIDTH       = $clog2(BURST_LENGTH) + 1,
    parameter int H_WIDTH       = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_WIDTH-1:0]    cfg_width,
    input  logic [H_WIDTH-1:0]    cfg_height,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  split_wen,
    output logic [DATA_WIDTH-1:0] split_din,
    output logic                  split_ren,
    output logic                  split_rst,
    input  logic                  split_valid,
    input  logic                  split_full,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [H_WIDTH-1:0]    m_row,
    output logic [W_WIDTH-1:0]    m_col,
    output logic                  m_win,
    output logic                  m_last
);

    localparam int IW = W_WIDTH + H_WIDTH;

    sched_state_t       r_state;
    logic [W_WIDTH-1:0] r_width;
    logic [W_WIDTH-1:0] r_col;
    logic [H_WIDTH-1:0] r_height;
    logic [H_WIDTH-1:0] r_row;
    logic [IW-1:0]      r_in_total;
    logic [IW-1:0]      r_in_cnt;
    logic               r_cfg_err;
    logic               w_run;
    logic               w_last_col;

    // Gating with rst keeps every handshake quiet while reset is held.
    assign w_run      = rst && (r_state == RUN);
    assign busy       = rst && (r_state != IDLE);
    assign done       = rst && (r_state == DONE);
    assign cfg_err    = rst && r_cfg_err;
    assign s_ready    = w_run && !split_full && (r_in_cnt < r_in_total);
    assign split_wen  = s_valid && s_ready;
    assign split_din  = s_data;
    assign split_ren  = w_run && m_ready;
    assign split_rst  = !rst || (r_state == FLUSH);
    assign m_valid    = w_run && split_valid;
    assign m_row      = r_row;
    assign m_col      = r_col;
    assign w_last_col = (r_col == r_width - 1'b1);
    assign m_win      = m_valid && (r_col >= W_WIDTH'(KERNEL_LENGTH - 1));
    assign m_last     = m_valid && w_last_col && (r_row == r_height - H_WIDTH'(KERNEL_LENGTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_width    <= '0;
            r_height   <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_in_total <= '0;
            r_in_cnt   <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok(32'(cfg_width), 32'(cfg_height), BURST_LENGTH, KERNEL_LENGTH)) begin
                            r_width    <= cfg_width;
                            r_height   <= cfg_height;
                            r_in_total <= IW'(cfg_width) * IW'(cfg_height);
                            r_in_cnt   <= '0;
                            r_col      <= '0;
                            r_row      <= '0;
                            r_state    <= RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (split_wen) r_in_cnt <= r_in_cnt + 1'b1;
                    if (m_valid) begin
                        r_col <= w_last_col ? '0 : r_col + 1'b1;
                        r_row <= w_last_col ? r_row + 1'b1 : r_row;
                        if (m_last) r_state <= FLUSH;
                    end
                end
                FLUSH: r_state <= DONE;
                DONE:  r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/split_sched.md
Name: split_sched

Overview:
- Sequencer for the `split` line-buffer cascade (KERNEL_LENGTH chained ring buffers that emit one KERNEL_LENGTH-tall pixel column per read).
- Sits between the DMA read stream and the convolution datapath.
- Accepts a frame job (width, height), meters pixels into `split`, and issues column reads under downstream backpressure.
- Tags each emitted column with row/col position and window-complete status, flushes leftover rows at frame end, and pulses done.

Parameters:
- DATA_WIDTH, 32, pixel width; must match `split`.
- BURST_LENGTH, 32, ring-buffer depth; this is the maximum image width.
- KERNEL_LENGTH, 3, kernel side; must match `split`.
- W_WIDTH, $clog2(BURST_LENGTH)+1, width of the cfg_width field.
- H_WIDTH, 12, width of the cfg_height field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  job start pulse, sampled in IDLE only.
- cfg_width  in  W_WIDTH  image width in pixels.
- cfg_height  in  H_WIDTH  image height in rows.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- s_valid  in  1  DMA pixel valid.
- s_ready  out  1  controller accepts a pixel.
- s_data  in  DATA_WIDTH  DMA pixel.
- split_wen  out  1  drives split.wen.
- split_din  out  DATA_WIDTH  drives split.din.
- split_ren  out  1  drives split.ren.
- split_rst  out  1  active-high reset to `split`.
- split_valid  in  1  from split.valid.
- split_full  in  1  from split.full_flag.
- m_ready  in  1  downstream can take a column.
- m_valid  out  1  column present on split.dout this cycle.
- m_row  out  H_WIDTH  output row index, 0..height-KERNEL_LENGTH.
- m_col  out  W_WIDTH  output column index, 0..width-1.
- m_win  out  1  m_valid && m_col >= KERNEL_LENGTH-1, i.e. the horizontal window is complete.
- m_last  out  1  m_valid on the final column of the frame.

Behaviour:

States: IDLE, RUN, FLUSH, DONE.

IDLE:
- On start, check the config.
- Reject if cfg_width==0, cfg_width>BURST_LENGTH, or cfg_height<KERNEL_LENGTH. On reject, pulse cfg_err for one cycle and stay in IDLE.
- Otherwise latch width and height, compute in_total = width*height (registered), clear all counters, and go to RUN.

RUN:
- Input side:
  - s_ready = !split_full && (in_cnt < in_total).
  - split_wen = s_valid && s_ready.
  - split_din = s_data, passed through combinationally.
  - in_cnt increments on each split_wen.
- Output side:
  - split_ren = m_ready.
  - m_valid = split_valid.
  - m_row, m_col, m_win, m_last are valid in the same cycle as m_valid, with zero added latency.
- Counters advance on m_valid:
  - m_col increments.
  - At width-1, m_col wraps to 0 and m_row increments.
- m_last = m_valid && m_row==height-KERNEL_LENGTH && m_col==width-1. The m_last cycle moves the FSM to FLUSH.
- Input and output may both fire in the same cycle; the counters are independent.

FLUSH (1 cycle):
- split_rst=1 to discard the KERNEL_LENGTH-1 residual rows held in the lower buffers.
- s_ready=0, split_ren=0.
- Go to DONE.

DONE (1 cycle):
- done=1, then go to IDLE.

Start handling:
- start while busy is ignored: no cfg_err, no state change.

Reset:
- split_rst = !rst || (state==FLUSH). The cascade is therefore cleared during controller reset.
- While rst is low, on the clock edge: state←IDLE, all counters←0, latched config←0.
- Reset mid-job aborts the job with no done pulse.

Reset values of outputs:
- 0: busy, done, cfg_err, s_ready, split_wen, split_ren, m_valid, m_row, m_col, m_win, m_last.
- split_din follows s_data.
- split_rst=1 while reset is asserted.

Widths:
- in_cnt and in_total are W_WIDTH+H_WIDTH bits. The product is unsigned, with no truncation.

Boundary rules:
- split_full held: s_ready low, no pixel lost, DMA stalls.
- m_ready low: no reads issued, m_valid low, counters hold.
- width==1: m_win is never asserted.
- width==BURST_LENGTH: legal; the buffer reaches full exactly at a row boundary.
- height==KERNEL_LENGTH: exactly width columns are output.

Decomposition:
- Package split_sched_pkg contains:
  - state enum typedef `sched_state_t` {IDLE,RUN,FLUSH,DONE}.
  - Function `cfg_ok(width,height)`, shared with the bench.
- No sub-module.
- The top level that instantiates split_sched together with `split` is a separate wrapper and is not part of this block.

Test Plan:
- Basic frame: cfg 4x3, K=3, s_valid and m_ready held high.
  - Exactly 4 m_valid, with m_row=0 and m_col 0..3.
  - m_win on cols 2 and 3; m_last on col 3.
  - One FLUSH cycle with split_rst=1, then done one cycle later.
  - 12 pixels accepted.
- Config reject: start with width 0, then with width 33, then with height 2.
  - cfg_err pulse for each, busy stays 0, and no split_wen occurs.
- Backpressure: cfg 8x5, m_ready toggled 1/0 every cycle, s_valid random at 50%.
  - 24 columns emitted in raster order (rows 0..2, cols 0..7) with no duplicate or skipped index.
  - 40 pixels accepted.
- Input stall at full: cfg 32x4 with m_ready=0.
  - s_ready drops when split_full rises, and no split_wen while full.
  - Releasing m_ready resumes, and the frame completes with 64 columns.
- Reset mid-frame: assert rst low for 1 cycle during RUN of a 6x6 job.
  - Next cycle: state IDLE, counters 0, split_rst was high, no done pulse.
  - A fresh 6x6 job then completes normally with 24 columns.
- Start while busy: pulse start during RUN with different cfg values.
  - Ignored; the original job's counts and done timing are unchanged.
